sd_cmd_tx: RTL and testbench
============================

Name: sd_cmd_tx

Overview:
- Command-path transmit stage of the SD host controller; sits directly downstream of command assembly and upstream of the CMD pad.
- Builds the 48-bit SD command frame from a 6-bit index and 32-bit argument.
- Frame layout: start bit, transmission bit, index, argument, CRC7, end bit.
- Computes the CRC7 bit-serially while shifting the first 40 bits, then serializes the whole frame MSB-first onto the CMD line with an output-enable for the bidirectional pad.

Parameters:
- CLKS_PER_BIT, 1, number of clk cycles each frame bit is held on cmd_out (SD bit period in system clocks); legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_start  input  1  request to send; sampled only in IDLE.
- cmd_index  input  6  command index, latched when cmd_start is accepted.
- cmd_arg  input  32  command argument, latched when cmd_start is accepted.
- busy  output  1  high while a frame is in progress, including the DONE cycle.
- done  output  1  single-cycle pulse after the end bit completes.
- cmd_out  output  1  serial CMD data to the pad.
- cmd_oe  output  1  pad output enable; high only while frame bits are driven.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; busy=0, done=0, cmd_out=1, cmd_oe=0.
  - CRC register, bit counter and divider counter cleared.
  - A frame in flight is abandoned immediately with no end bit; the line is released.
- Frame, bit 47 down to 0:
  - bit47=0 (start), bit46=1 (transmission).
  - bits45:40=cmd_index, bits39:8=cmd_arg.
  - bits7:1=CRC7[6:0], bit0=1 (end).
- CRC7:
  - Polynomial x^7+x^3+1, register initialised to 0 on acceptance.
  - Updated once per bit for bits 47..8, at the last cycle of that bit's period: fb=bit^crc[6]; crc={crc[5:0],1'b0}^(fb?7'h09:7'h00).
  - Result is final before bit 7 is driven.
- States:
  - IDLE: busy=0, cmd_oe=0, cmd_out=1. On a clk edge with cmd_start=1, latch the inputs and go to SEND.
  - SEND: cmd_oe=1, cmd_out=current frame bit. The divider counts 0..CLKS_PER_BIT-1; at its terminal count the bit counter decrements. Leaving bit 0 goes to DONE.
  - DONE: one cycle; done=1, busy=1, cmd_oe=0, cmd_out=1. Then IDLE.
- Timing (with K=CLKS_PER_BIT):
  - Start accepted at edge N.
  - cmd_oe=1 and busy=1 for cycles N+1 .. N+48K.
  - done=1 in cycle N+48K+1.
  - IDLE from cycle N+48K+2; a new cmd_start may be accepted at that edge.
- cmd_start while busy (SEND or DONE): ignored, not queued.
- cmd_index/cmd_arg changes after acceptance have no effect on the frame in flight.
- Outputs are registered; no combinational path from inputs to outputs.
- Bit counter is 6 bits, divider counter 8 bits. No wrap-around is reachable in legal use.

Test Plan:
- CMD0, arg 0x00000000, K=1 -> serial frame 0x400000000095 (CRC 7'b1001010); cmd_oe high exactly 48 cycles; done pulses once at cycle N+49.
- CMD17, arg 0x00000000 -> frame 0x510000000055 (CRC 7'b0101010). CMD8, arg 0x000001AA -> frame 0x48000001AA87. CMD55, arg 0 -> frame 0x770000000065.
- K=4, CMD0 -> each bit stable for exactly 4 cycles; cmd_oe high 192 cycles; done at N+193; frame identical to the K=1 case.
- Pulse cmd_start again at bit 20 and during the DONE cycle, changing cmd_arg to 0xFFFFFFFF -> current frame unchanged, no second frame. Hold cmd_start high continuously -> back-to-back frames with exactly one IDLE cycle (cmd_oe=0, cmd_out=1) between them.
- Assert reset asynchronously (not on a clk edge) mid-argument -> cmd_oe=0, cmd_out=1, busy=0, done=0 immediately, with no done pulse. Next CMD17 after release -> correct frame 0x510000000055.
- Idle check after reset with cmd_start=0 for 100 cycles -> cmd_out=1, cmd_oe=0, busy=0, done=0 throughout.

Source files
------------

// File: rtl/sd_cmd_tx.sv
// SD command-line transmitter: builds the 48-bit command frame, computes CRC7
// serially over the first 40 bits and drives it MSB-first with a pad output enable.
module sd_cmd_tx #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        busy,
  output logic        done,
  output logic        cmd_out,
  output logic        cmd_oe
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned HDR_W = 40;
  localparam int unsigned CRC_W = 7;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FIRST_BIT = CNT_W'(47);
  localparam logic [CNT_W-1:0] CRC_BIT = CNT_W'(8);
  localparam logic [CRC_W-1:0] CRC_POLY = CRC_W'(7'h09);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_d;

  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             bit_end_c;
  logic             fb_c;

  logic busy_d, done_d, cmd_out_d, cmd_oe_d;

  assign bit_end_c = (div_q == DIV_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cmd_start) state_d = SEND;
      SEND:    if (bit_end_c && (bit_q == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: header shifter, CRC7 and bit/divider counters
  always_comb begin
    hdr_d = hdr_q;
    crc_d = crc_q;
    bit_d = bit_q;
    div_d = div_q;
    fb_c  = hdr_q[HDR_W-1] ^ crc_q[CRC_W-1];
    case (state)
      IDLE: begin
        if (cmd_start) begin
          hdr_d = {2'b01, cmd_index, cmd_arg};
          crc_d = '0;
          bit_d = FIRST_BIT;
          div_d = '0;
        end
      end
      SEND: begin
        if (bit_end_c) begin
          div_d = '0;
          bit_d = bit_q - CNT_W'(1);
          if (bit_q >= CRC_BIT) begin
            hdr_d = {hdr_q[HDR_W-2:0], 1'b0};
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb_c ? CRC_POLY : '0);
          end else begin
            // CRC is final; shift it out MSB-first
            crc_d = {crc_q[CRC_W-2:0], 1'b0};
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_q <= '0;
      crc_q <= '0;
      bit_q <= '0;
      div_q <= '0;
    end else begin
      hdr_q <= hdr_d;
      crc_q <= crc_d;
      bit_q <= bit_d;
      div_q <= div_d;
    end
  end

  // Output decode from next-cycle state so the pad outputs can be registered
  always_comb begin
    busy_d    = 1'b0;
    done_d    = 1'b0;
    cmd_out_d = 1'b1;
    cmd_oe_d  = 1'b0;
    case (state_d)
      SEND: begin
        busy_d   = 1'b1;
        cmd_oe_d = 1'b1;
        if (bit_d >= CRC_BIT)  cmd_out_d = hdr_d[HDR_W-1];
        else if (bit_d != '0)  cmd_out_d = crc_d[CRC_W-1];
        else                   cmd_out_d = 1'b1;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      cmd_out <= 1'b1;
      cmd_oe  <= 1'b0;
    end else begin
      busy    <= busy_d;
      done    <= done_d;
      cmd_out <= cmd_out_d;
      cmd_oe  <= cmd_oe_d;
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Bench for sd_cmd_tx: directed SD commands plus random frames checked against
// a frame/CRC7 reference model, at one and four clocks per bit.
module tb_sd_cmd_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start4;
  logic [5:0]  idx;
  logic [31:0] arg;
  logic        busy1, done1, out1, oe1;
  logic        busy4, done4, out4, oe4;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sd_cmd_tx #(.CLKS_PER_BIT(1)) u_k1 (
    .clk(clk), .reset(reset), .cmd_start(start1), .cmd_index(idx), .cmd_arg(arg),
    .busy(busy1), .done(done1), .cmd_out(out1), .cmd_oe(oe1)
  );

  sd_cmd_tx #(.CLKS_PER_BIT(4)) u_k4 (
    .clk(clk), .reset(reset), .cmd_start(start4), .cmd_index(idx), .cmd_arg(arg),
    .busy(busy4), .done(done4), .cmd_out(out4), .cmd_oe(oe4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame as defined by the SD command format, CRC7 = x^7+x^3+1 over 40 header bits
  function automatic logic [47:0] ref_frame(input logic [5:0] i, input logic [31:0] a);
    logic [39:0] h;
    logic [6:0]  c;
    logic        fb;
    h = {2'b01, i, a};
    c = '0;
    for (int b = 39; b >= 0; b--) begin
      fb = h[b] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return {h, c, 1'b1};
  endfunction

  task automatic sample(input bit use4, output logic b, output logic d, output logic o, output logic e);
    b = use4 ? busy4 : busy1;
    d = use4 ? done4 : done1;
    o = use4 ? out4  : out1;
    e = use4 ? oe4   : oe1;
  endtask

  // Send one frame, capture it from the line and check framing/timing
  task automatic send(input bit use4, input logic [5:0] i_idx, input logic [31:0] i_arg,
                      input bit disturb, output logic [47:0] frame);
    int k;
    int oe_cnt, bad_ctl, bad_stab, bad_idle;
    logic b, d, o, e, prev;
    k = use4 ? 4 : 1;
    oe_cnt = 0; bad_ctl = 0; bad_stab = 0; bad_idle = 0;
    frame = '0;
    prev = 1'b1;
    @(negedge clk);
    idx = i_idx; arg = i_arg;
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    for (int c = 0; c < 48 * k; c++) begin
      sample(use4, b, d, o, e);
      if (e === 1'b1) oe_cnt++;
      if (b !== 1'b1 || d !== 1'b0) bad_ctl++;
      if (c % k == 0) frame[47 - c / k] = o;
      else if (o !== prev) bad_stab++;
      prev = o;
      if (disturb && c == 27 * k) begin
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        arg = 32'hFFFF_FFFF;
      end
      if (disturb && c == 27 * k + 1) begin
        start1 = 1'b0; start4 = 1'b0;
      end
      @(negedge clk);
    end
    sample(use4, b, d, o, e);
    chk("done_cycle", {60'd0, b, d, o, e}, 64'hE);
    if (disturb) begin
      if (use4) start4 = 1'b1; else start1 = 1'b1;
    end
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    sample(use4, b, d, o, e);
    chk("idle_after", {60'd0, b, d, o, e}, 64'h2);
    if (disturb) begin
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        sample(use4, b, d, o, e);
        if (e !== 1'b0 || b !== 1'b0 || d !== 1'b0) bad_idle++;
      end
      chk("no_second_frame", 64'(bad_idle), 64'd0);
    end
    chk("oe_cycles", 64'(oe_cnt), 64'(48 * k));
    chk("busy_during", 64'(bad_ctl), 64'd0);
    chk("bit_stable", 64'(bad_stab), 64'd0);
  endtask

  logic [47:0] f, f2;
  logic [5:0]  r_idx;
  logic [31:0] r_arg;
  int          bad, bad_pat;

  initial begin
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0; idx = '0; arg = '0;
    #1;
    chk("reset_k1", {60'd0, busy1, done1, out1, oe1}, 64'h2);
    chk("reset_k4", {60'd0, busy4, done4, out4, oe4}, 64'h2);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ({busy1, done1, out1, oe1} !== 4'h2 || {busy4, done4, out4, oe4} !== 4'h2) bad++;
    end
    chk("idle_100", 64'(bad), 64'd0);

    send(1'b0, 6'd0, 32'h0, 1'b0, f);
    chk("cmd0_k1", 64'(f), 64'h4000_0000_0095);
    send(1'b0, 6'd17, 32'h0, 1'b0, f);
    chk("cmd17", 64'(f), 64'h5100_0000_0055);
    send(1'b0, 6'd8, 32'h0000_01AA, 1'b0, f);
    chk("cmd8", 64'(f), 64'h4800_0001_AA87);
    send(1'b0, 6'd55, 32'h0, 1'b0, f);
    chk("cmd55", 64'(f), 64'h7700_0000_0065);
    send(1'b1, 6'd0, 32'h0, 1'b0, f);
    chk("cmd0_k4", 64'(f), 64'h4000_0000_0095);
    send(1'b0, 6'd17, 32'h0, 1'b1, f);
    chk("cmd17_disturbed", 64'(f), 64'h5100_0000_0055);

    // Back-to-back frames with cmd_start held high
    @(negedge clk);
    idx = 6'd17; arg = 32'h0; start1 = 1'b1;
    bad_pat = 0; f = '0; f2 = '0;
    for (int c = 0; c < 98; c++) begin
      @(negedge clk);
      if (c < 48) begin
        if (oe1 !== 1'b1) bad_pat++;
        f[47 - c] = out1;
      end else if (c == 48) begin
        if ({busy1, done1, out1, oe1} !== 4'hE) bad_pat++;
      end else if (c == 49) begin
        if ({busy1, done1, out1, oe1} !== 4'h2) bad_pat++;
      end else begin
        if (oe1 !== 1'b1) bad_pat++;
        f2[47 - (c - 50)] = out1;
      end
    end
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_pattern", 64'(bad_pat), 64'd0);
    chk("b2b_frame1", 64'(f), 64'h5100_0000_0055);
    chk("b2b_frame2", 64'(f2), 64'h5100_0000_0055);

    // Asynchronous reset in the middle of the argument
    @(negedge clk);
    idx = 6'd8; arg = 32'hDEAD_BEEF; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {60'd0, busy1, done1, out1, oe1}, 64'h2);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if ({busy1, done1, out1, oe1} !== 4'h2) bad++;
    end
    reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if ({busy1, done1, out1, oe1} !== 4'h2) bad++;
    end
    chk("no_done_after_reset", 64'(bad), 64'd0);
    send(1'b0, 6'd17, 32'h0, 1'b0, f);
    chk("cmd17_after_reset", 64'(f), 64'h5100_0000_0055);

    for (int n = 0; n < 8; n++) begin
      r_idx = 6'($urandom);
      r_arg = $urandom;
      send(1'b0, r_idx, r_arg, 1'b0, f);
      chk("rand_k1", 64'(f), 64'(ref_frame(r_idx, r_arg)));
    end
    for (int n = 0; n < 3; n++) begin
      r_idx = 6'($urandom);
      r_arg = $urandom;
      send(1'b1, r_idx, r_arg, 1'b0, f);
      chk("rand_k4", 64'(f), 64'(ref_frame(r_idx, r_arg)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
